led_blink_bank: RTL and testbench

//  Parametrised bank of NUM_CH independent LED blink channels. Each channel has a

---
 rtl/led_blink_pkg.sv | 27 ++
 rtl/led_blink_channel.sv | 121 ++++++++++++
 rtl/led_blink_bank.sv | 51 +++++
 tb/tb_led_blink_bank.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared mode codes, burst sub-state encoding and 25 MHz default timing for the
// LED blink bank.
package led_blink_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_ON   = 2'd1,
        B_OFF  = 2'd2
    } burst_state_t;

    localparam int CLK_HZ    = 25_000_000;
    localparam int HALF_10HZ = CLK_HZ / 20;
    localparam int HALF_5HZ  = CLK_HZ / 10;
    localparam int HALF_2HZ  = CLK_HZ / 4;
    localparam int HALF_1HZ  = CLK_HZ / 2;

    // Channel-select width; a single-channel bank still needs a 1-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: half-period counter, mode register, burst sequencer and the
// registered LED / done outputs.
module led_blink_channel
    import led_blink_pkg::*;
#(
    parameter int                   CNT_WIDTH   = 24,
    parameter int                   BURST_WIDTH = 8,
    parameter logic [CNT_WIDTH-1:0] RST_HALF    = CNT_WIDTH'(HALF_10HZ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [1:0]             wr_mode,
    input  logic [CNT_WIDTH-1:0]   wr_half,
    input  logic [BURST_WIDTH-1:0] wr_burst,
    input  logic                   sync,
    output logic                   led,
    output logic                   done
);

    logic [1:0]             mode_q, mode_d;
    burst_state_t           bstate_q, bstate_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   half_q, half_d;
    logic [BURST_WIDTH-1:0] rem_q, rem_d;
    logic                   led_q, led_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH-1:0]   last_cnt;
    logic                   toggle;
    logic                   active;

    // A half-period of zero behaves as one: the LED toggles every clock.
    assign last_cnt = (half_q == '0) ? '0 : half_q - 1'b1;
    assign toggle   = (cnt_q == last_cnt);
    assign active   = (mode_q == MODE_BLINK) ||
                      ((mode_q == MODE_BURST) && (bstate_q != B_IDLE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= MODE_BLINK;
            bstate_q <= B_IDLE;
            cnt_q    <= '0;
            half_q   <= RST_HALF;
            rem_q    <= '0;
            led_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            mode_q   <= mode_d;
            bstate_q <= bstate_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            rem_q    <= rem_d;
            led_q    <= led_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        mode_d   = mode_q;
        bstate_d = bstate_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        rem_d    = rem_q;
        led_d    = led_q;
        done_d   = 1'b0;

        if (wr_en) begin
            mode_d   = wr_mode;
            half_d   = wr_half;
            cnt_d    = '0;
            rem_d    = '0;
            bstate_d = B_IDLE;
            case (wr_mode)
                MODE_OFF:   led_d = 1'b0;
                MODE_ON:    led_d = 1'b1;
                MODE_BLINK: led_d = 1'b1;
                default: begin
                    rem_d = wr_burst;
                    if (wr_burst == '0) begin
                        led_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        led_d    = 1'b1;
                        bstate_d = B_ON;
                    end
                end
            endcase
        end else if (sync && active) begin
            // Re-phase without touching rem: an interrupted off phase restarts as on.
            cnt_d = '0;
            led_d = 1'b1;
            if (mode_q == MODE_BURST) bstate_d = B_ON;
        end else if (active) begin
            if (!toggle) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
                if (mode_q == MODE_BLINK) begin
                    led_d = ~led_q;
                end else if (bstate_q == B_ON) begin
                    bstate_d = B_OFF;
                    led_d    = 1'b0;
                    if (rem_q != '0) rem_d = rem_q - 1'b1;
                end else if (rem_q != '0) begin
                    bstate_d = B_ON;
                    led_d    = 1'b1;
                end else begin
                    bstate_d = B_IDLE;
                    led_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
        end
    end

    assign led  = led_q;
    assign done = done_q;

endmodule

// File: rtl/led_blink_bank.sv
// Bank of NUM_CH independent LED blink channels sharing one write port and a
// common phase-align strobe.
module led_blink_bank
    import led_blink_pkg::*;
#(
    parameter int                          NUM_CH      = 4,
    parameter int                          CNT_WIDTH   = 24,
    parameter int                          BURST_WIDTH = 8,
    parameter logic [NUM_CH*CNT_WIDTH-1:0] RST_HALF    = {CNT_WIDTH'(HALF_1HZ),
                                                          CNT_WIDTH'(HALF_2HZ),
                                                          CNT_WIDTH'(HALF_5HZ),
                                                          CNT_WIDTH'(HALF_10HZ)}
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    input  logic                          i_Wr_En,
    input  logic [ch_width(NUM_CH)-1:0]   i_Wr_Ch,
    input  logic [1:0]                    i_Wr_Mode,
    input  logic [CNT_WIDTH-1:0]          i_Wr_Half,
    input  logic [BURST_WIDTH-1:0]        i_Wr_Burst,
    input  logic                          i_Sync,
    output logic [NUM_CH-1:0]             o_LED,
    output logic [NUM_CH-1:0]             o_Done
);

    localparam int CH_W = ch_width(NUM_CH);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic wr_en_ch;

        // Selects at or beyond NUM_CH match no channel, so such writes are dropped.
        assign wr_en_ch = i_Wr_En && (i_Wr_Ch == CH_W'(ch));

        led_blink_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .BURST_WIDTH (BURST_WIDTH),
            .RST_HALF    (RST_HALF[ch*CNT_WIDTH +: CNT_WIDTH])
        ) u_channel (
            .clk      (i_Clk),
            .rst_n    (i_Rst_n),
            .wr_en    (wr_en_ch),
            .wr_mode  (i_Wr_Mode),
            .wr_half  (i_Wr_Half),
            .wr_burst (i_Wr_Burst),
            .sync     (i_Sync),
            .led      (o_LED[ch]),
            .done     (o_Done[ch])
        );
    end

endmodule

// File: tb/tb_led_blink_bank.sv
// Self-checking bench for led_blink_bank: directed scenarios plus random traffic
// against an elapsed-time model of each channel.
module tb_led_blink_bank;

    localparam int CW = 8;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en_a, wr_en_b;
    logic [1:0]    wr_ch_a;
    logic [2:0]    wr_ch_b;
    logic [1:0]    wr_mode;
    logic [CW-1:0] wr_half;
    logic [BW-1:0] wr_burst;
    logic          sync;
    logic [3:0]    led_a, done_a;
    logic [4:0]    led_b, done_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    led_blink_bank #(
        .NUM_CH(4), .CNT_WIDTH(CW), .BURST_WIDTH(BW),
        .RST_HALF({8'd8, 8'd6, 8'd4, 8'd2})
    ) u_dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Wr_En(wr_en_a), .i_Wr_Ch(wr_ch_a),
        .i_Wr_Mode(wr_mode), .i_Wr_Half(wr_half), .i_Wr_Burst(wr_burst),
        .i_Sync(sync), .o_LED(led_a), .o_Done(done_a)
    );

    // Five channels give a 3-bit select, so out-of-range channels are reachable.
    led_blink_bank #(
        .NUM_CH(5), .CNT_WIDTH(CW), .BURST_WIDTH(BW),
        .RST_HALF({8'd0, 8'd3, 8'd7, 8'd1, 8'd5})
    ) u_dut_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Wr_En(wr_en_b), .i_Wr_Ch(wr_ch_b),
        .i_Wr_Mode(wr_mode), .i_Wr_Half(wr_half), .i_Wr_Burst(wr_burst),
        .i_Sync(sync), .o_LED(led_b), .o_Done(done_b)
    );

    // Model: each channel remembers the edge of its last restart (anchor), and the
    // outputs follow from the number of elapsed half-periods since then.
    int rst_half [2][5] = '{'{2, 4, 6, 8, 0}, '{5, 1, 7, 3, 0}};
    int nch      [2]    = '{4, 5};
    int m_mode   [2][5];
    int m_half   [2][5];
    int m_pulses [2][5];
    int m_anchor [2][5];
    bit m_aled   [2][5];

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic logic exp_led(input int d, input int c);
        int e = cyc - m_anchor[d][c];
        int p = e / m_half[d][c];
        case (m_mode[d][c])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return m_aled[d][c] ^ logic'(p % 2);
            default: return (p < 2 * m_pulses[d][c]) && (p % 2 == 0);
        endcase
    endfunction

    function automatic logic exp_done(input int d, input int c);
        int e = cyc - m_anchor[d][c];
        return (m_mode[d][c] == 3) && (e == 2 * m_pulses[d][c] * m_half[d][c]);
    endfunction

    function automatic logic [17:0] exp_all();
        logic [17:0] v = '0;
        for (int c = 0; c < 4; c++) begin
            v[14+c] = exp_led(0, c);
            v[10+c] = exp_done(0, c);
        end
        for (int c = 0; c < 5; c++) begin
            v[5+c] = exp_led(1, c);
            v[c]   = exp_done(1, c);
        end
        return v;
    endfunction

    task automatic model_edge(input int d);
        logic en = (d == 0) ? wr_en_a : wr_en_b;
        int   ch = (d == 0) ? int'(wr_ch_a) : int'(wr_ch_b);
        for (int c = 0; c < nch[d]; c++) begin
            if (!rst_n) begin
                m_mode[d][c]   = 2;
                m_half[d][c]   = at_least_one(rst_half[d][c]);
                m_pulses[d][c] = 0;
                m_anchor[d][c] = cyc;
                m_aled[d][c]   = 1'b0;
            end else if (en && ch == c) begin
                m_mode[d][c]   = int'(wr_mode);
                m_half[d][c]   = at_least_one(int'(wr_half));
                m_pulses[d][c] = int'(wr_burst);
                m_anchor[d][c] = cyc;
                m_aled[d][c]   = 1'b1;
            end else if (sync) begin
                int e = cyc - 1 - m_anchor[d][c];
                int p = e / m_half[d][c];
                if (m_mode[d][c] == 2) begin
                    m_anchor[d][c] = cyc;
                    m_aled[d][c]   = 1'b1;
                end else if (m_mode[d][c] == 3 && e < 2 * m_pulses[d][c] * m_half[d][c]) begin
                    // Pulses still owed = total minus on-phases already finished.
                    m_pulses[d][c] = at_least_one(m_pulses[d][c] - (p + 1) / 2);
                    m_anchor[d][c] = cyc;
                    m_aled[d][c]   = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic write_a(input int ch, input int mode, input int half, input int burst);
        wr_en_a  = 1'b1;
        wr_ch_a  = 2'(ch);
        wr_mode  = 2'(mode);
        wr_half  = CW'(half);
        wr_burst = BW'(burst);
    endtask

    task automatic test_reset();
        int tog0 = 0, tog3 = 0;
        logic [3:0] prev = 4'b0;
        rst_n = 1'b0;
        repeat (2) step();
        if ({led_a, done_a, led_b, done_b} !== 18'b0) begin
            miscompares++;
            $display("FAIL reset_state got=%h want=0", {led_a, done_a, led_b, done_b});
        end
        vectors++;
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            if ({led_a, done_a, led_b, done_b} !== exp_all()) begin
                miscompares++;
                $display("FAIL reset_run cyc=%0d got=%h want=%h", cyc, {led_a, done_a, led_b, done_b}, exp_all());
            end
            vectors++;
            if (led_a[0] != prev[0]) tog0++;
            if (led_a[3] != prev[3]) tog3++;
            prev = led_a;
        end
        if (tog0 != 16 || tog3 != 4) begin
            miscompares++;
            $display("FAIL reset_toggle_count ch0=%0d ch3=%0d want 16 and 4", tog0, tog3);
        end
        vectors++;
    endtask

    task automatic test_blink_write();
        write_a(1, 2, 3, 0);
        step();
        wr_en_a = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (led_a[1] !== logic'(((k - 1) / 3) % 2 == 0)) begin
                miscompares++;
                $display("FAIL blink_half3 k=%0d got=%b want=%b", k, led_a[1], ((k - 1) / 3) % 2 == 0);
            end
            vectors++;
            if ({led_a, done_a, led_b, done_b} !== exp_all()) begin
                miscompares++;
                $display("FAIL blink_model cyc=%0d got=%h want=%h", cyc, {led_a, done_a, led_b, done_b}, exp_all());
            end
            vectors++;
            step();
        end
    endtask

    task automatic test_burst();
        int hi = 0, done_k = 0, done_n = 0;
        write_a(2, 3, 2, 3);
        step();
        wr_en_a = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (led_a[2]) hi++;
            if (done_a[2]) begin
                done_n++;
                done_k = k;
            end
            if ({led_a, done_a, led_b, done_b} !== exp_all()) begin
                miscompares++;
                $display("FAIL burst_model cyc=%0d got=%h want=%h", cyc, {led_a, done_a, led_b, done_b}, exp_all());
            end
            vectors++;
            step();
        end
        if (hi != 6 || done_n != 1 || done_k != 13) begin
            miscompares++;
            $display("FAIL burst_shape high=%0d done=%0d at=%0d want 6 1 13", hi, done_n, done_k);
        end
        vectors++;
    endtask

    task automatic test_zero_cases();
        write_a(3, 3, 4, 0);
        step();
        wr_en_a = 1'b0;
        if (led_a[3] !== 1'b0 || done_a[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_zero led=%b done=%b want 0 1", led_a[3], done_a[3]);
        end
        vectors++;
        step();
        if (led_a[3] !== 1'b0 || done_a[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_zero_after led=%b done=%b want 0 0", led_a[3], done_a[3]);
        end
        vectors++;
        write_a(0, 2, 0, 0);
        step();
        wr_en_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (led_a[0] !== logic'(k % 2) || {led_a, done_a, led_b, done_b} !== exp_all()) begin
                miscompares++;
                $display("FAIL half_zero k=%0d got=%h want=%h", k, {led_a, done_a, led_b, done_b}, exp_all());
            end
            vectors++;
            step();
        end
    endtask

    task automatic test_sync();
        write_a(0, 2, 5, 0);
        step();
        wr_en_a = 1'b0;
        repeat (2) step();
        write_a(1, 2, 5, 0);
        step();
        write_a(2, 1, 5, 0);
        step();
        write_a(3, 0, 5, 0);
        step();
        wr_en_a = 1'b0;
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        if (led_a !== 4'b0111) begin
            miscompares++;
            $display("FAIL sync_align got=%b want=0111", led_a);
        end
        vectors++;
        for (int k = 0; k < 12; k++) begin
            step();
            if (led_a[0] !== led_a[1] || led_a[3:2] !== 2'b01 || {led_a, done_a, led_b, done_b} !== exp_all()) begin
                miscompares++;
                $display("FAIL sync_phase cyc=%0d got=%h want=%h", cyc, {led_a, done_a, led_b, done_b}, exp_all());
            end
            vectors++;
        end
        write_a(0, 0, 5, 0);
        sync = 1'b1;
        step();
        sync    = 1'b0;
        wr_en_a = 1'b0;
        if (led_a[1:0] !== 2'b10 || {led_a, done_a, led_b, done_b} !== exp_all()) begin
            miscompares++;
            $display("FAIL sync_write_wins got=%h want=%h", {led_a, done_a, led_b, done_b}, exp_all());
        end
        vectors++;
    endtask

    task automatic test_reset_mid_burst();
        write_a(2, 3, 3, 4);
        step();
        wr_en_a = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (done_a !== 4'b0 || {led_a, done_a, led_b, done_b} !== exp_all()) begin
                miscompares++;
                $display("FAIL reset_mid_burst cyc=%0d got=%h want=%h", cyc, {led_a, done_a, led_b, done_b}, exp_all());
            end
            vectors++;
        end
    endtask

    task automatic test_bad_channel();
        wr_en_b  = 1'b1;
        wr_ch_b  = 3'd5;
        wr_mode  = 2'd1;
        wr_half  = 8'd1;
        wr_burst = 4'd0;
        step();
        wr_ch_b = 3'd7;
        wr_mode = 2'd0;
        step();
        wr_en_b = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if ({led_a, done_a, led_b, done_b} !== exp_all()) begin
                miscompares++;
                $display("FAIL bad_channel cyc=%0d got=%h want=%h", cyc, {led_a, done_a, led_b, done_b}, exp_all());
            end
            vectors++;
            step();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            wr_en_a  = ($urandom_range(0, 3) == 0);
            wr_ch_a  = 2'($urandom);
            wr_en_b  = ($urandom_range(0, 3) == 0);
            wr_ch_b  = 3'($urandom);
            wr_mode  = 2'($urandom);
            wr_half  = CW'($urandom_range(0, 6));
            wr_burst = BW'($urandom_range(0, 4));
            sync     = ($urandom_range(0, 11) == 0);
            step();
            if ({led_a, done_a, led_b, done_b} !== exp_all()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, {led_a, done_a, led_b, done_b}, exp_all());
            end
            vectors++;
        end
        rst_n   = 1'b1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        sync    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en_a  = 1'b0;
        wr_en_b  = 1'b0;
        wr_ch_a  = '0;
        wr_ch_b  = '0;
        wr_mode  = '0;
        wr_half  = '0;
        wr_burst = '0;
        sync     = 1'b0;
        test_reset();
        test_blink_write();
        test_burst();
        test_zero_cases();
        test_sync();
        test_reset_mid_burst();
        test_bad_channel();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
